// File: rtl/if_id_ibuf_pkg.sv
// Shared widths, NOP encoding and entry layout for the IF->ID instruction buffer.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

package if_id_ibuf_pkg;
  localparam int IBUF_DEPTH = 4;
  localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH) + 1;

  typedef struct packed {
    logic [`PC_SIZE-1:0]    pc;
    logic [`INSTR_SIZE-1:0] instr;
    logic                   take;
  } ibuf_entry_t;
endpackage

// File: rtl/if_id_ibuf_if.sv
// Fetch-side and decode-side handshake bundle of the instruction buffer.
interface if_id_ibuf_if #(
  parameter int PC_W    = `PC_SIZE,
  parameter int INSTR_W = `INSTR_SIZE
);
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_take;
  logic               if_stall;
  logic               id_valid;
  logic               id_ready;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic               id_take;

  modport master (
    output if_valid, if_pc, if_instr, if_take, id_ready,
    input  if_stall, id_valid, id_pc, id_instr, id_take
  );
  modport slave (
    input  if_valid, if_pc, if_instr, if_take, id_ready,
    output if_stall, id_valid, id_pc, id_instr, id_take
  );
endinterface

// File: rtl/if_id_ibuf_mem.sv
// DEPTH-entry register file: one write port, one asynchronous read port, no reset.
module ibuf_mem
  import if_id_ibuf_pkg::*;
#(
  parameter  int DEPTH = IBUF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [AW-1:0] waddr_i,
  input  ibuf_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ibuf_entry_t rdata_o
);
  ibuf_entry_t mem_q [DEPTH];

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    always_ff @(posedge clk) begin
      if (we_i && (waddr_i == AW'(e))) mem_q[e] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_ibuf.sv
// In-order instruction buffer between fetch and decode with redirect flush.
// Optional zero-latency empty bypass under macro IBUF_BYPASS_EN.
module if_id_ibuf
  import if_id_ibuf_pkg::*;
#(
  parameter  int DEPTH   = IBUF_DEPTH,
  parameter  int PC_W    = `PC_SIZE,
  parameter  int INSTR_W = `INSTR_SIZE,
  localparam int PTR_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  if_id_ibuf_if.slave      bus,
  input  logic             flush_i,
  output logic [PTR_W-1:0] count_o
);
  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic             full, empty, push, pop, byp;
  ibuf_entry_t      wdata, head;

  // Extra MSB on the pointers keeps full and empty distinct.
  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign full  = (cnt == PTR_W'(DEPTH));
  assign empty = (cnt == '0);

`ifdef IBUF_BYPASS_EN
  assign byp = empty & bus.if_valid & bus.id_ready & ~flush_i;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word is consumed straight from fetch and never stored.
  assign push = bus.if_valid & ~full & ~flush_i & ~byp;
  assign pop  = ~empty & ~flush_i & bus.id_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wdata = '{pc:    `PC_SIZE'(bus.if_pc),
                   instr: `INSTR_SIZE'(bus.if_instr),
                   take:  bus.if_take};

  ibuf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head)
  );

  // Stall depends on registered occupancy only, never on id_ready.
  assign bus.if_stall = full;
  assign bus.id_valid = byp | (~empty & ~flush_i);
  assign bus.id_pc    = byp   ? bus.if_pc    :
                        empty ? '0           : PC_W'(head.pc);
  assign bus.id_instr = byp   ? bus.if_instr :
                        empty ? INSTR_W'(`INSTR_NOP) : INSTR_W'(head.instr);
  assign bus.id_take  = byp   ? bus.if_take  : (~empty & head.take);
  assign count_o      = cnt;
endmodule

// File: tb/tb_if_id_ibuf.sv
// Directed self-checking bench for if_id_ibuf (default and IBUF_BYPASS_EN builds).
module tb_if_id_ibuf;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;
  int         total = 0;
  int         bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_ibuf_if bus ();

  if_id_ibuf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flush_i (flush),
    .count_o (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = 32'hA000_0000 | pc;
    bus.if_take  = pc[2];
    bus.id_ready = rdy;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0);
    // reset state
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stall", 32'(bus.if_stall), 32'd0);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_pc",    bus.id_pc, 32'h0);
    chk("rst_instr", bus.id_instr, NOP);
    chk("rst_take",  32'(bus.id_take), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 1: fill to DEPTH with decode stalled; 5th word rejected
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0);
      tick();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_stall", 32'(bus.if_stall), 32'd1);
    chk("fill_pc",    bus.id_pc, 32'h00);
    chk("fill_valid", 32'(bus.id_valid), 32'd1);
    drive(1'b1, 32'h10, 1'b0);
    tick();
    chk("rej_count", 32'(count), 32'd4);
    chk("rej_pc",    bus.id_pc, 32'h00);

    // 2: drain from full while fetch re-presents 0x10 then 0x14
    drive(1'b1, 32'h10, 1'b1); #1;
    chk("d0_pc", bus.id_pc, 32'h00);
    chk("d0_stall", 32'(bus.if_stall), 32'd1);
    tick();
    chk("d0_count", 32'(count), 32'd3);
    chk("d0_stall_drop", 32'(bus.if_stall), 32'd0);
    chk("d1_pc", bus.id_pc, 32'h04);
    chk("d1_take", 32'(bus.id_take), 32'd1);
    tick();
    chk("d1_count", 32'(count), 32'd3);
    drive(1'b1, 32'h14, 1'b1); #1;
    chk("d2_pc", bus.id_pc, 32'h08);
    tick();
    chk("d2_count", 32'(count), 32'd3);
    drive(1'b0, 32'h0, 1'b1); #1;
    chk("d3_pc", bus.id_pc, 32'h0C);
    tick();
    chk("d3_count", 32'(count), 32'd2);
    chk("d4_pc", bus.id_pc, 32'h10);
    chk("d4_instr", bus.id_instr, 32'hA000_0010);
    tick();
    chk("d4_count", 32'(count), 32'd1);
    chk("d5_pc", bus.id_pc, 32'h14);
    tick();
    chk("d5_count", 32'(count), 32'd0);
    chk("d5_valid", 32'(bus.id_valid), 32'd0);
    chk("d5_instr", bus.id_instr, NOP);

    // 3: flush at count=3 with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 1'b0);
      tick();
    end
    chk("pre_fl_count", 32'(count), 32'd3);
    drive(1'b1, 32'h80, 1'b1);
    flush = 1'b1; #1;
    chk("fl_valid_now", 32'(bus.id_valid), 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0); #1;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(bus.id_valid), 32'd0);
    chk("fl_instr", bus.id_instr, NOP);
    chk("fl_pc",    bus.id_pc, 32'h0);
    drive(1'b1, 32'h200, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0); #1;
    chk("postfl_pc", bus.id_pc, 32'h200);
    chk("postfl_count", 32'(count), 32'd1);
    chk("postfl_valid", 32'(bus.id_valid), 32'd1);
    bus.id_ready = 1'b1;
    tick();
    chk("postfl_drain", 32'(count), 32'd0);

    // 4: 20 cycles of push+pop at occupancy 1, pointers wrap
    drive(1'b1, 32'h300, 1'b0);
    tick();
    chk("str_prime", 32'(count), 32'd1);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h304 + 32'(k * 4), 1'b1); #1;
      chk($sformatf("str_pc%0d", k), bus.id_pc, 32'h300 + 32'(k * 4));
      tick();
      chk($sformatf("str_cnt%0d", k), 32'(count), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("str_drain", 32'(count), 32'd0);

    // 5: empty buffer, word arrives with decode ready
    drive(1'b1, 32'h40, 1'b1); #1;
`ifdef IBUF_BYPASS_EN
    chk("byp_valid", 32'(bus.id_valid), 32'd1);
    chk("byp_pc",    bus.id_pc, 32'h40);
    chk("byp_count", 32'(count), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0); #1;
    chk("byp_after_count", 32'(count), 32'd0);
    chk("byp_after_valid", 32'(bus.id_valid), 32'd0);
`else
    chk("nobyp_valid", 32'(bus.id_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0); #1;
    chk("nobyp_pc",    bus.id_pc, 32'h40);
    chk("nobyp_count", 32'(count), 32'd1);
    bus.id_ready = 1'b1;
    tick();
    chk("nobyp_drain", 32'(count), 32'd0);
`endif

    // 6: asynchronous reset mid-cycle with count=2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_stall", 32'(bus.if_stall), 32'd0);
    chk("arst_pc",    bus.id_pc, 32'h0);
    chk("arst_instr", bus.id_instr, NOP);
    #4 rst_n = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_ibuf.md
Name: if_id_ibuf

Overview:
- Instruction buffer on the consumer side of the fetch stage.
- Accepts {pc, instr, take} each cycle fetch presents a valid word, and presents entries in order to decode with a valid/ready handshake.
- Back-pressures fetch when full and discards all buffered entries on a redirect flush (branch mispredict or jalr resolution).
- Decouples fetch from decode stalls.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- PC_W, `PC_SIZE, width of the pc field.
- INSTR_W, `INSTR_SIZE, width of the instruction field.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- if_valid  input  1  fetch presents a valid entry this cycle.
- if_pc  input  PC_W  pc of the fetched instruction.
- if_instr  input  INSTR_W  fetched instruction, already NOP-substituted by fetch.
- if_take  input  1  predecode predicted-taken flag.
- if_stall  output  1  buffer full; fetch must hold its pc.
- id_valid  output  1  head entry is valid for decode.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_pc  output  PC_W  head entry pc.
- id_instr  output  INSTR_W  head entry instruction.
- id_take  output  1  head entry predicted-taken flag.
- flush  input  1  redirect (predict_fail or id_jalr); discard all entries.
- count  output  clog2(DEPTH)+1  current occupancy, for debug/perf.

Behaviour:
- Storage
  - Circular array of DEPTH entries {pc, instr, take}.
  - wr_ptr and rd_ptr are clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Indices wrap modulo DEPTH.
- Reset (rst_n low, asynchronous)
  - wr_ptr = rd_ptr = 0, count = 0, if_stall = 0, id_valid = 0.
  - id_pc = 0, id_instr = `INSTR_NOP, id_take = 0.
  - Storage contents are don't-care.
  - Deassertion is synchronous to clk via the standard reset synchroniser outside the block.
- Handshakes
  - push = if_valid & !full & !flush.
  - pop = id_valid & id_ready.
  - full = (count == DEPTH); empty = (count == 0).
  - if_stall = full, computed from registered state only, with no combinational path from id_ready.
  - Push while full is rejected. Fetch holds its pc and re-presents the same entry, so nothing is lost.
  - Simultaneous push and pop when 0 < count < DEPTH: both occur and count is unchanged.
  - Push while full with a pop in the same cycle: push is still rejected, because if_stall is already high. Count drops by 1 and if_stall deasserts next cycle.
- Outputs
  - id_valid = !empty & !flush.
  - id_pc/id_instr/id_take show the entry at rd_ptr when non-empty.
  - When empty they show 0 / `INSTR_NOP / 0.
- Latency: an entry pushed at edge N is visible at decode from cycle N+1 (one cycle).
- Flush
  - At the next edge, wr_ptr = rd_ptr = 0 and count = 0.
  - A push or pop in the flush cycle is discarded; id_valid is forced 0 in that cycle.
  - The first post-redirect entry from fetch is accepted in the cycle after flush.
- Flush while empty: no effect beyond resetting the pointers.
- Reset mid-operation: all entries are lost and outputs return to their reset values immediately.

Optional Feature:
- Macro: IBUF_BYPASS_EN.
- Defined:
  - When empty, if_valid, id_ready and !flush, the incoming entry drives id_* combinationally and id_valid = 1.
  - The entry is consumed without being written (zero latency); the pointers do not move.
  - If id_ready is low, the entry is written normally.
- Undefined: strict one-cycle latency with no combinational path from if_* to id_*.

Decomposition:
- Shared package/defines holds:
  - `PC_SIZE, `INSTR_SIZE, `INSTR_NOP.
  - IBUF_DEPTH default.
  - IBUF_PTR_W = clog2(IBUF_DEPTH)+1.
  - Entry typedef ibuf_entry_t {pc, instr, take}.
- One sub-module: ibuf_mem.
  - DEPTH x entry register array, one write port, one asynchronous read port.
  - Control (pointers, count, flush, bypass) stays in if_id_ibuf.

Test Plan:
1. Reset, then push 4 entries (pc 0x00,0x04,0x08,0x0C) with id_ready=0 -> count=4, if_stall=1, id_pc=0x00. A 5th if_valid (pc 0x10) is rejected and count stays 4.
2. From full, hold id_ready=1 and if_valid=1 with pc 0x10,0x14 -> pops come out as 0x00,0x04,0x08,0x0C,0x10,0x14 in order. Count never exceeds 4, and if_stall drops one cycle after the first pop.
3. Count=3, assert flush together with if_valid (pc 0x80) and id_ready -> next cycle count=0, id_valid=0, id_instr=`INSTR_NOP, and pc 0x80 is not stored. The cycle after, push pc 0x200 -> id_pc=0x200.
4. Continuous push and pop for 20 cycles with pc incrementing by 4 -> output sequence equals input sequence, count constant at 1, pointers wrap cleanly past DEPTH.
5. With IBUF_BYPASS_EN, empty buffer, if_valid=1 with pc 0x40, id_ready=1 -> id_valid=1 and id_pc=0x40 in the same cycle, count stays 0. Without the macro -> id_valid=0 that cycle, then id_pc=0x40 the next cycle.
6. Assert rst_n=0 mid-clock with count=2 -> id_valid, if_stall and count go to 0 immediately, without waiting for a clk edge.
